// File: rtl/aes_bus_master_if.sv
// aes_bus_master_if: command/response streams and the AES register-slave bus
interface aes_bus_master_if;
    logic         cmd_valid, cmd_ready, cmd_encdec, cmd_new_key;
    logic [127:0] cmd_key, cmd_block;
    logic         res_valid, res_ready, res_err;
    logic [127:0] res_data;
    logic         busy;
    logic         cs, we;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;
    modport master (
        input  cmd_valid, cmd_encdec, cmd_new_key, cmd_key, cmd_block, res_ready, read_data,
        output cmd_ready, res_valid, res_data, res_err, busy, cs, we, address, write_data
    );
    modport slave (
        output cmd_valid, cmd_encdec, cmd_new_key, cmd_key, cmd_block, res_ready, read_data,
        input  cmd_ready, res_valid, res_data, res_err, busy, cs, we, address, write_data
    );
endinterface

// File: rtl/aes_bus_master.sv
// aes_bus_master: runs one AES block job per command over the register-mapped slave bus
module aes_bus_master #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1023
) (
    input logic              clk,
    input logic              reset_n,
    aes_bus_master_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, WR_CFG, WR_KEY, WR_INIT, SETTLE_K, POLL_K,
        WR_BLK, WR_NEXT, SETTLE_B, POLL_B, RD_RES, RESP
    } state_t;
    localparam logic [7:0] A_CTRL = 8'h08, A_STATUS = 8'h09, A_CFG = 8'h0a;
    state_t       state;
    logic         new_key;
    logic [127:0] key, blk;
    logic [95:0]  acc;
    logic [1:0]   idx, nidx;
    logic [15:0]  cnt;
    logic [31:0]  key_w, blk_w;
    logic         poll_ok;
    assign nidx        = idx + 2'd1;
    assign key_w       = key[{~nidx, 5'd0} +: 32];
    assign blk_w       = blk[{~nidx, 5'd0} +: 32];
    assign poll_ok     = state == POLL_K ? bus.read_data[0] : &bus.read_data[1:0];
    assign bus.busy    = state != IDLE;
    assign bus.cmd_ready = state == IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            {bus.cs, bus.we, bus.address, bus.write_data} <= '0;
            {bus.res_valid, bus.res_err, bus.res_data} <= '0;
            {new_key, key, blk, acc, idx, cnt} <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    {new_key, key, blk} <= {bus.cmd_new_key, bus.cmd_key, bus.cmd_block};
                    {bus.cs, bus.we, bus.address, bus.write_data} <= {2'b11, A_CFG, 31'h0, bus.cmd_encdec};
                    state <= WR_CFG;
                end
                WR_CFG: begin
                    idx <= 2'd0;
                    {bus.address, bus.write_data} <= new_key ? {8'h10, key[127:96]} : {8'h20, blk[127:96]};
                    state <= new_key ? WR_KEY : WR_BLK;
                end
                WR_KEY: begin
                    idx <= nidx;
                    {bus.address, bus.write_data} <= idx == 2'd3 ? {A_CTRL, 32'h1} : {6'h04, nidx, key_w};
                    state <= idx == 2'd3 ? WR_INIT : WR_KEY;
                end
                WR_BLK: begin
                    idx <= nidx;
                    {bus.address, bus.write_data} <= idx == 2'd3 ? {A_CTRL, 32'h2} : {6'h08, nidx, blk_w};
                    state <= idx == 2'd3 ? WR_NEXT : WR_BLK;
                end
                WR_INIT, WR_NEXT: begin
                    {bus.cs, bus.we, bus.address, bus.write_data} <= '0;
                    cnt <= 16'(SETTLE - 1);
                    state <= state == WR_INIT ? SETTLE_K : SETTLE_B;
                end
                SETTLE_K, SETTLE_B: begin
                    cnt <= cnt == 16'd0 ? 16'd0 : cnt - 16'd1;
                    {bus.cs, bus.address} <= cnt == 16'd0 ? {1'b1, A_STATUS} : 9'h0;
                    if (cnt == 16'd0) state <= state == SETTLE_K ? POLL_K : POLL_B;
                end
                // success wins over timeout when both land on the same poll
                POLL_K, POLL_B: begin
                    cnt <= cnt + 16'd1;
                    if (poll_ok) begin
                        idx <= 2'd0;
                        {bus.we, bus.address, bus.write_data} <= state == POLL_K ? {1'b1, 8'h20, blk[127:96]} : {1'b0, 8'h30, 32'h0};
                        state <= state == POLL_K ? WR_BLK : RD_RES;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        {bus.cs, bus.address} <= 9'h0;
                        {bus.res_valid, bus.res_err, bus.res_data} <= {2'b11, 128'h0};
                        state <= RESP;
                    end
                end
                RD_RES: begin
                    idx <= nidx;
                    acc <= {acc[63:0], bus.read_data};
                    {bus.cs, bus.address} <= idx == 2'd3 ? 9'h0 : {1'b1, 6'h0c, nidx};
                    if (idx == 2'd3) begin
                        {bus.res_valid, bus.res_err, bus.res_data} <= {2'b10, acc, bus.read_data};
                        state <= RESP;
                    end
                end
                RESP: if (bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_bus_master.sv
// tb_aes_bus_master: directed jobs against a stub AES register slave with a response scoreboard
module tb_aes_bus_master;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic clk = 1'b0, reset_n = 1'b0;
    int tests = 0, fails = 0;
    aes_bus_master_if bus();
    aes_bus_master #(.SETTLE(4), .TIMEOUT(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stub slave: knows the FIPS-197 pair, otherwise returns a keyed scramble
    function automatic logic [127:0] aes_stub(input logic [127:0] k, input logic [127:0] b, input logic e);
        if (k == FK && e && b == PT) return CT;
        if (k == FK && !e && b == CT) return PT;
        return b ^ k ^ {128{e}};
    endfunction

    logic [31:0]  s_key [4];
    logic [31:0]  s_blk [4];
    logic         s_enc = 1'b0, s_ready = 1'b1, s_valid = 1'b0, s_op = 1'b0, stuck = 1'b0;
    logic [127:0] s_res = '0;
    int           s_cnt = 0;
    always @(posedge clk) begin
        if (bus.cs && bus.we) begin
            if (bus.address == 8'h0a) s_enc <= bus.write_data[0];
            else if (bus.address[7:2] == 6'h04) s_key[bus.address[1:0]] <= bus.write_data;
            else if (bus.address[7:2] == 6'h08) s_blk[bus.address[1:0]] <= bus.write_data;
            else if (bus.address == 8'h08 && bus.write_data[0]) begin
                {s_ready, s_valid, s_op} <= 3'b000;
                s_cnt <= 6;
            end else if (bus.address == 8'h08 && bus.write_data[1]) begin
                {s_ready, s_valid, s_op} <= 3'b001;
                s_cnt <= 7;
                s_res <= aes_stub({s_key[0], s_key[1], s_key[2], s_key[3]}, {s_blk[0], s_blk[1], s_blk[2], s_blk[3]}, s_enc);
            end
        end else if (s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) {s_ready, s_valid} <= {1'b1, s_op};
        end
    end
    always_comb begin
        bus.read_data = 32'h0;
        if (bus.cs && !bus.we) begin
            if (bus.address == 8'h09) bus.read_data = stuck ? 32'h0 : {30'h0, s_valid, s_ready};
            else if (bus.address[7:2] == 6'h0c) bus.read_data = s_res[{~bus.address[1:0], 5'd0} +: 32];
        end
    end

    // Bus trace and CTRL-to-first-poll gap measurement, cleared whenever the master is idle
    logic [40:0]  trace [$];
    logic [40:0]  exp_q [$];
    int           gaps [$];
    int           gap = 0;
    bit           armed = 0, next_seen = 0;
    logic [128:0] sb [$];
    always @(negedge clk) begin
        if (!bus.busy) begin
            trace.delete();
            gaps.delete();
            {armed, next_seen} = 2'b00;
        end
        if (bus.cs) trace.push_back({bus.we, bus.address, bus.we ? bus.write_data : bus.read_data});
        if (bus.cs && bus.we && bus.address == 8'h08) begin
            armed = 1;
            gap = 0;
            if (bus.write_data == 32'h2) next_seen = 1;
        end else if (armed && !bus.cs) gap++;
        else if (armed && !bus.we && bus.address == 8'h09) begin
            gaps.push_back(gap);
            armed = 0;
        end
    end
    always @(negedge clk) if (reset_n && bus.res_valid && bus.res_ready) begin
        logic [128:0] e;
        check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
        e = sb.size() != 0 ? sb.pop_front() : 129'h0;
        check("res_data", bus.res_data, e[127:0]);
        check("res_err", 128'(bus.res_err), 128'(e[128]));
    end

    task automatic build_exp(input logic enc, input logic nk, input logic [127:0] k, input logic [127:0] b,
                             input logic [127:0] r, input int stage);
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h0a, 31'h0, enc});
        if (nk) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h10 + 8'(i), k[32*(3-i) +: 32]});
            exp_q.push_back({1'b1, 8'h08, 32'h1});
        end
        if (stage == 1) return;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i), b[32*(3-i) +: 32]});
        exp_q.push_back({1'b1, 8'h08, 32'h2});
        if (stage == 2) return;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h30 + 8'(i), r[32*(3-i) +: 32]});
    endtask

    task automatic check_trace(input string tag);
        logic [40:0] f [$];
        foreach (trace[i]) if (trace[i][40:32] != {1'b0, 8'h09}) f.push_back(trace[i]);
        check({tag, "_len"}, 128'(f.size()), 128'(exp_q.size()));
        for (int i = 0; i < f.size() && i < exp_q.size(); i++) check(tag, 128'(f[i]), 128'(exp_q[i]));
    endtask

    function automatic int polls(input bit after_next);
        int n = 0;
        bit seen = 0;
        foreach (trace[i]) begin
            if (trace[i] == {1'b1, 8'h08, 32'h2}) seen = 1;
            else if (trace[i][40:32] == {1'b0, 8'h09} && seen == after_next) n++;
        end
        return n;
    endfunction

    task automatic send(input logic enc, input logic nk, input logic [127:0] k, input logic [127:0] b,
                        input logic [128:0] exp);
        @(negedge clk);
        check("cmd_ready_idle", 128'(bus.cmd_ready), 128'd1);
        {bus.cmd_valid, bus.cmd_encdec, bus.cmd_new_key, bus.cmd_key, bus.cmd_block} = {1'b1, enc, nk, k, b};
        sb.push_back(exp);
        @(posedge clk);
        #1;
        {bus.cmd_valid, bus.cmd_encdec, bus.cmd_new_key} = {1'b0, ~enc, ~nk};
        bus.cmd_key   = {4{$urandom}};
        bus.cmd_block = {4{$urandom}};
    endtask

    task automatic run_job(input logic enc, input logic nk, input logic [127:0] k, input logic [127:0] b,
                           input logic [128:0] exp, output int n);
        send(enc, nk, k, b, exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 600);
        check("resp_wait", 128'(bus.res_valid), 128'd1);
    endtask

    task automatic finish_job();
        @(posedge clk);
        #1;
        check("res_valid_drop", 128'(bus.res_valid), 128'd0);
        check("cmd_ready_back", 128'(bus.cmd_ready), 128'd1);
    endtask

    task automatic check_latency(input logic nk, input int n);
        int pk = polls(0), pb = polls(1);
        check("poll_b_seen", 128'(pb > 0), 128'd1);
        check("latency", 128'(n - 1), 128'(1 + (nk ? 9 + pk : 0) + 13 + pb));
    endtask

    initial begin
        int n;
        logic [127:0] rb, d;
        logic e;
        {bus.cmd_valid, bus.cmd_encdec, bus.cmd_new_key, bus.cmd_key, bus.cmd_block} = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("rst_bus", 128'({bus.cs, bus.we, bus.address, bus.write_data}), 128'd0);
        check("rst_res", {bus.res_valid, bus.res_err, bus.res_data[125:0]}, 128'd0);
        check("rst_ctl", 128'({bus.res_data[127:126], bus.busy, bus.cmd_ready}), 128'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_job(1, 1, FK, PT, {1'b0, CT}, n);
        build_exp(1, 1, FK, PT, CT, 0);
        check_trace("fips_enc_trace");
        check_latency(1, n);
        check("settle_gap_cnt", 128'(gaps.size()), 128'd2);
        foreach (gaps[i]) check("settle_gap", 128'(gaps[i]), 128'd4);
        finish_job();

        run_job(0, 0, FK, CT, {1'b0, PT}, n);
        build_exp(0, 0, FK, CT, PT, 0);
        check_trace("fips_dec_trace");
        check_latency(0, n);
        finish_job();

        rb = {$urandom, $urandom, $urandom, $urandom};
        run_job(1, 0, 128'h0, rb, {1'b0, aes_stub(FK, rb, 1'b1)}, n);
        build_exp(1, 0, 128'h0, rb, aes_stub(FK, rb, 1'b1), 0);
        check_trace("rand_enc_trace");
        finish_job();

        bus.res_ready = 1'b0;
        run_job(1, 0, FK, PT, {1'b0, CT}, n);
        {e, d} = {bus.res_err, bus.res_data};
        check("bp_data", d, CT);
        repeat (20) begin
            @(negedge clk);
            check("bp_hold", {bus.res_valid, bus.res_err, d[125:0]}, {1'b1, e, bus.res_data[125:0]});
            check("bp_bus", 128'({bus.cmd_ready, bus.cs, bus.busy, bus.res_data[127:126]}), 128'({3'b001, d[127:126]}));
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        finish_job();

        stuck = 1'b1;
        run_job(1, 1, FK, PT, {1'b1, 128'h0}, n);
        check("tmo_k_polls", 128'(polls(0)), 128'd8);
        build_exp(1, 1, FK, PT, 128'h0, 1);
        check_trace("tmo_k_trace");
        finish_job();
        run_job(1, 0, FK, PT, {1'b1, 128'h0}, n);
        check("tmo_b_polls", 128'(polls(1)), 128'd8);
        build_exp(1, 0, FK, PT, 128'h0, 2);
        check_trace("tmo_b_trace");
        finish_job();
        stuck = 1'b0;
        run_job(1, 1, FK, PT, {1'b0, CT}, n);
        finish_job();

        send(1, 1, FK, PT, {1'b0, CT});
        n = 0;
        while (!(next_seen && bus.cs && !bus.we && bus.address == 8'h09) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_poll_b", 128'(next_seen && bus.cs && !bus.we && bus.address == 8'h09), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_bus", 128'({bus.cs, bus.we, bus.address, bus.write_data}), 128'd0);
        check("mid_rst_res", {bus.res_valid, bus.res_err, bus.res_data[125:0]}, 128'd0);
        check("mid_rst_ctl", 128'({bus.res_data[127:126], bus.busy, bus.cmd_ready}), 128'd1);
        sb.delete();
        repeat (3) @(negedge clk);
        check("rst_hold", 128'({bus.cs, bus.busy, bus.res_valid, bus.cmd_ready}), 128'd1);
        reset_n = 1'b1;
        run_job(1, 1, FK, PT, {1'b0, CT}, n);
        build_exp(1, 1, FK, PT, CT, 0);
        check_trace("post_rst_trace");
        finish_job();

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
